// File: rtl/patch_window_buffer.sv
// patch_window_buffer
// Streaming WIN x WIN window generator. Keeps WIN-1 previous image lines in a
// column-addressed line store, assembles a sliding window register and emits the
// full patch plus its centre coordinate for every fully-inside window position.
// Optional framing check: define PATCH_FRAME_CHECK_EN to validate i_end against the
// pixel count (default build ignores i_end and ties o_frame_err low).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for an accepted pixel carrying i_start
//   S_RUN  | inside a frame, counting pixels and emitting windows
module patch_window_buffer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PIX_W  = 8,
    parameter int WIN    = 31
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [PIX_W-1:0]         i_pixel,
    input  logic                     i_start,
    input  logic                     i_end,
    output logic                     o_valid,
    output logic [11:0]              o_x,
    output logic [11:0]              o_y,
    output logic [WIN*WIN*PIX_W-1:0] o_window,
    output logic                     o_start,
    output logic                     o_end,
    output logic                     o_busy,
    output logic                     o_frame_err
);

    localparam int R  = (WIN - 1) / 2;
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [11:0] X_LAST = 12'(WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(HEIGHT - 1);
    localparam logic [11:0] EDGE   = 12'(WIN - 1);
    localparam logic [11:0] RAD    = 12'(R);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state;
    logic [11:0]       cx, cy;
    logic [11:0]       pos_x, pos_y;
    logic              take, at_last, emit, end_err;
    logic [AW-1:0]     addr;

    logic [PIX_W-1:0]  line_mem [WIN-1][WIDTH];
    logic [PIX_W-1:0]  col      [WIN];
    logic [PIX_W-1:0]  win_q    [WIN][WIN];
    logic [PIX_W-1:0]  win_d    [WIN][WIN];

    // Position of the pixel on the input this cycle; i_start always means (0,0)
    always_comb begin
        take    = i_valid && (i_start || (state == S_RUN));
        pos_x   = i_start ? 12'd0 : cx;
        pos_y   = i_start ? 12'd0 : cy;
        at_last = (pos_x == X_LAST) && (pos_y == Y_LAST);
        emit    = take && (pos_x >= EDGE) && (pos_y >= EDGE);
        addr    = pos_x[AW-1:0];
    end

`ifdef PATCH_FRAME_CHECK_EN
    logic end_flag;
    logic end_miss;
    logic frame_err_q;

    // i_end loses to i_start on the same pixel
    always_comb begin
        end_flag = i_end && !i_start;
        end_err  = take && end_flag && !at_last;
        end_miss = take && at_last && !end_flag;
    end

    // Framing error pulse, one cycle after the offending pixel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= end_err || end_miss;
        end
    end

    assign o_frame_err = frame_err_q;
`else
    logic unused_end;

    assign unused_end  = i_end;
    assign end_err     = 1'b0;
    assign o_frame_err = 1'b0;
`endif

    // New column: oldest stored line at the top, incoming pixel at the bottom
    always_comb begin
        col[WIN-1] = i_pixel;
        for (int r = 0; r < WIN - 1; r++) begin
            col[r] = line_mem[WIN-2-r][addr];
        end
    end

    // Window after this pixel: shift left one column, new column enters at the right
    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][WIN-1] = col[r];
        end
    end

    // Line store and window register; contents are hidden by gating, so no reset
    always_ff @(posedge i_clk) begin
        if (take) begin
            line_mem[0][addr] <= i_pixel;
            for (int k = 1; k < WIN - 1; k++) begin
                line_mem[k][addr] <= line_mem[k-1][addr];
            end
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    // Frame FSM, raster counters and registered window outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            cx       <= 12'd0;
            cy       <= 12'd0;
            o_valid  <= 1'b0;
            o_start  <= 1'b0;
            o_end    <= 1'b0;
            o_busy   <= 1'b0;
            o_x      <= 12'd0;
            o_y      <= 12'd0;
            o_window <= '0;
        end else begin
            o_valid <= emit;
            o_start <= emit && (pos_x == EDGE) && (pos_y == EDGE);
            o_end   <= emit && at_last;
            if (emit) begin
                o_x <= pos_x - RAD;
                o_y <= pos_y - RAD;
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN; c++) begin
                        o_window[((r*WIN)+c)*PIX_W +: PIX_W] <= win_d[r][c];
                    end
                end
            end
            if (take) begin
                if (at_last || end_err) begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    cx     <= 12'd0;
                    cy     <= 12'd0;
                end else begin
                    state  <= S_RUN;
                    o_busy <= 1'b1;
                    if (pos_x == X_LAST) begin
                        cx <= 12'd0;
                        cy <= pos_y + 12'd1;
                    end else begin
                        cx <= pos_x + 12'd1;
                        cy <= pos_y;
                    end
                end
            end
        end
    end

endmodule
